tms_wb_loader: RTL and testbench

Wishbone classic slave between the Caravel management-SoC user bus and the wrapped TMS1x00 core. Firmware sets a load pointer, streams program bytes into a small write FIFO, and the FIFO drains into the core's program-ROM write port. The block holds the TMS1x00 core in reset until firmware sets RUN and every queued byte has been committed to ROM.

---
 rtl/tms_wb_pkg.sv | 31 +++
 rtl/tms_wb_fifo.sv | 63 ++++++
 rtl/tms_wb_loader.sv | 170 +++++++++++++++++
 tb/tb_tms_wb_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tms_wb_pkg.sv
// tms_wb_pkg: shared definitions for the TMS1x00 program loader.
//   - Register word offsets (wbs_adr_i[7:2]) for CTRL / STATUS / PTR / DATA.
//   - STATUS bit positions.
//   - Write-FIFO entry layout {addr, data}; addr is carried at ENTRY_AW bits
//     and the loader uses the low ROM_AW bits (ROM_AW <= ENTRY_AW).
//   - Drain FSM state encoding.
package tms_wb_pkg;

    localparam logic [5:0] REG_CTRL   = 6'h00;
    localparam logic [5:0] REG_STATUS = 6'h01;
    localparam logic [5:0] REG_PTR    = 6'h02;
    localparam logic [5:0] REG_DATA   = 6'h03;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_LEVEL_LSB = 8;

    localparam int ENTRY_AW = 16;

    typedef struct packed {
        logic [ENTRY_AW-1:0] addr;
        logic [7:0]          data;
    } fifo_entry_t;

    typedef enum logic {
        DRAIN_IDLE  = 1'b0,
        DRAIN_WRITE = 1'b1
    } drain_state_t;

endpackage

// File: rtl/tms_wb_fifo.sv
// tms_wb_fifo: synchronous FIFO, DEPTH entries (power of two, >= 2) of WIDTH bits.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (empties the FIFO)
//   push, wdata     write an entry (caller ensures !full, or pop in the same cycle)
//   pop             drop the head entry (caller ensures !empty)
//   head            entry at the read pointer
//   next            entry behind the head (valid when level >= 2)
//   level           number of stored entries
//   full, empty     level == DEPTH / level == 0
module tms_wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] next,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr_next;

    assign rd_ptr_next = rd_ptr + 1'b1;
    assign head        = mem[rd_ptr];
    // Exposed so the drain can move to the following entry without a bubble.
    assign next        = mem[rd_ptr_next];
    assign full        = (level == LW'(DEPTH));
    assign empty       = (level == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr_next;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid. A push into a
    // full FIFO with a simultaneous pop overwrites the slot being read out,
    // which is safe because head is read before the edge.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tms_wb_loader.sv
// tms_wb_loader: Wishbone classic slave that streams program bytes into the
// TMS1x00 program ROM and holds the core in reset until loading is done.
// Ports:
//   wb_clk_i, wb_rst_n          clock, synchronous active-low reset
//   wbs_cyc_i/stb_i/we_i        Wishbone request
//   wbs_sel_i, wbs_adr_i        byte lanes, byte address
//   wbs_dat_i / wbs_dat_o       write / read data
//   wbs_ack_o                   one-cycle acknowledge
//   rom_we, rom_addr, rom_wdata ROM write request (commits when rom_we & rom_ready)
//   rom_ready                   ROM accepts the write this cycle
//   core_rst_n                  active-low core reset
// Handshake: a request is accepted when it hits the window and ack is low;
// ack rises on the following edge for exactly one cycle. A DATA write that
// finds the FIFO full is not accepted (wait states) until the drain commits
// an entry, in which case push and pop share the same edge.
module tms_wb_loader
    import tms_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          ROM_AW     = 11,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [7:0]        rom_wdata,
    input  logic              rom_ready,
    output logic              core_rst_n
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    drain_state_t      state;
    logic              run;
    logic [ROM_AW-1:0] ptr;
    logic [ROM_AW-1:0] ptr_lane;
    logic [5:0]        offset;
    logic              hit;
    logic              data_wr;
    logic              accept;
    logic              push;
    logic              pop;
    logic [31:0]       read_val;
    fifo_entry_t       push_entry;
    fifo_entry_t       head;
    fifo_entry_t       next_entry;
    logic [LW-1:0]     fifo_level;
    logic              fifo_full;
    logic              fifo_empty;

    assign offset  = wbs_adr_i[7:2];
    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign data_wr = hit & wbs_we_i & (offset == REG_DATA) & wbs_sel_i[0];
    assign pop     = (state == DRAIN_WRITE) & rom_ready;
    assign accept  = hit & ~wbs_ack_o & ~(data_wr & fifo_full & ~pop);
    assign push    = accept & data_wr;

    // Bits of the bus not decoded by any register.
    logic unused_ok;
    assign unused_ok = &{1'b0, wbs_adr_i[1:0], wbs_sel_i, wbs_dat_i, head, next_entry};

    always_comb begin
        push_entry                  = '0;
        push_entry.addr[ROM_AW-1:0] = ptr;
        push_entry.data             = wbs_dat_i[7:0];
    end

    // PTR write merged per byte lane.
    always_comb begin
        ptr_lane = ptr;
        for (int i = 0; i < ROM_AW; i++) begin
            if (wbs_sel_i[i / 8]) ptr_lane[i] = wbs_dat_i[i];
        end
    end

    always_comb begin
        read_val = '0;
        case (offset)
            REG_CTRL:   read_val[0] = run;
            REG_STATUS: begin
                read_val[STAT_EMPTY]             = fifo_empty;
                read_val[STAT_FULL]              = fifo_full;
                read_val[STAT_BUSY]              = ~fifo_empty | rom_we;
                read_val[STAT_LEVEL_LSB +: LW]   = fifo_level;
            end
            REG_PTR:    read_val[ROM_AW-1:0] = ptr;
            default:    read_val = '0;
        endcase
    end

    tms_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_n),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .head  (head),
        .next  (next_entry),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            run        <= 1'b0;
            ptr        <= '0;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_wdata  <= '0;
            core_rst_n <= 1'b0;
            state      <= DRAIN_IDLE;
        end else begin
            wbs_ack_o <= accept;
            wbs_dat_o <= (accept & ~wbs_we_i) ? read_val : '0;

            if (accept & wbs_we_i) begin
                case (offset)
                    REG_CTRL: if (wbs_sel_i[0]) run <= wbs_dat_i[0];
                    REG_PTR:  ptr <= ptr_lane;
                    default:  ;
                endcase
            end
            // Pointer wraps naturally at 2^ROM_AW.
            if (push) ptr <= ptr + 1'b1;

            core_rst_n <= run & fifo_empty & ~rom_we;

            case (state)
                DRAIN_IDLE: begin
                    if (!fifo_empty) begin
                        rom_we    <= 1'b1;
                        rom_addr  <= head.addr[ROM_AW-1:0];
                        rom_wdata <= head.data;
                        state     <= DRAIN_WRITE;
                    end
                end
                DRAIN_WRITE: begin
                    if (rom_ready) begin
                        // An entry pushed this same cycle into a one-entry FIFO
                        // is not yet readable; IDLE picks it up next cycle.
                        if (fifo_level > LW'(1)) begin
                            rom_addr  <= next_entry.addr[ROM_AW-1:0];
                            rom_wdata <= next_entry.data;
                        end else begin
                            rom_we <= 1'b0;
                            state  <= DRAIN_IDLE;
                        end
                    end
                end
                default: state <= DRAIN_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tms_wb_loader.sv
// tb_tms_wb_loader: directed bench for tms_wb_loader. ROM commits are checked
// against an expected queue filled whenever a DATA byte is written.
module tb_tms_wb_loader;

    localparam logic [31:0] A_CTRL   = 32'h3000_0000;
    localparam logic [31:0] A_STATUS = 32'h3000_0004;
    localparam logic [31:0] A_PTR    = 32'h3000_0008;
    localparam logic [31:0] A_DATA   = 32'h3000_000C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_w;
    logic        ack;
    logic [31:0] dat_r;
    logic        rom_we;
    logic [10:0] rom_addr;
    logic [7:0]  rom_wdata;
    logic        rom_ready;
    logic        core_rst_n;

    int vectors    = 0;
    int miscompares = 0;
    int commit_cnt = 0;
    logic [31:0] exp_q[$];
    logic [10:0] ptr_model = '0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    tms_wb_loader dut (
        .wb_clk_i   (clk),
        .wb_rst_n   (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dat_w),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dat_r),
        .rom_we     (rom_we),
        .rom_addr   (rom_addr),
        .rom_wdata  (rom_wdata),
        .rom_ready  (rom_ready),
        .core_rst_n (core_rst_n)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a commit happens at the posedge following this sample.
    always @(negedge clk) begin
        #1;
        if (rst_n === 1'b1 && rom_we === 1'b1 && rom_ready === 1'b1) begin
            commit_cnt++;
            if (exp_q.size() == 0)
                check("rom_unexpected", {13'b0, rom_addr, rom_wdata}, 32'hFFFF_FFFF);
            else
                check("rom_write", {13'b0, rom_addr, rom_wdata}, exp_q.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d; sel = s;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 50);
        check("write_ack", {31'b0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        int n = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 50);
        check("read_ack", {31'b0, ack}, 32'd1);
        d = dat_r;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        wb_read(a, d);
        check(tag, d, exp);
    endtask

    task automatic data_write(input logic [7:0] b);
        exp_q.push_back({13'b0, ptr_model, b});
        ptr_model = ptr_model + 11'd1;
        wb_write(A_DATA, {24'h0, b}, 4'h1);
    endtask

    task automatic ptr_write(input logic [10:0] p);
        ptr_model = p;
        wb_write(A_PTR, {21'h0, p}, 4'hF);
    endtask

    task automatic wait_drain;
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_done", exp_q.size(), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c0;
        int stall_acks;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = '0; dat_w = '0; rom_ready = 1'b0;
        repeat (3) @(negedge clk);

        // 1: reset state
        check("rst_ack",        {31'b0, ack},        32'd0);
        check("rst_dat_o",      dat_r,               32'd0);
        check("rst_rom_we",     {31'b0, rom_we},     32'd0);
        check("rst_rom_addr",   {21'b0, rom_addr},   32'd0);
        check("rst_rom_wdata",  {24'b0, rom_wdata},  32'd0);
        check("rst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
        rst_n = 1'b1;
        read_check("status_reset", A_STATUS, 32'h0000_0001);
        read_check("ctrl_reset",   A_CTRL,   32'h0000_0000);
        check("core_rst_idle", {31'b0, core_rst_n}, 32'd0);

        // 2: basic stream
        rom_ready = 1'b1;
        ptr_write(11'h010);
        data_write(8'hA5);
        data_write(8'h5A);
        wait_drain();
        read_check("ptr_after_2", A_PTR,    32'h0000_0012);
        read_check("status_2",    A_STATUS, 32'h0000_0001);
        read_check("data_reads0", A_DATA,   32'h0000_0000);
        // DATA without sel[0]: acked, no push, no increment
        wb_write(A_DATA, 32'h0000_00EE, 4'h2);
        read_check("ptr_nosel",   A_PTR,    32'h0000_0012);

        // 3: full FIFO stalls the fifth write
        rom_ready = 1'b0;
        for (int i = 0; i < 4; i++) data_write(8'h30 + 8'(i));
        read_check("status_full", A_STATUS, 32'h0000_0406);
        exp_q.push_back({13'b0, ptr_model, 8'h34});
        ptr_model = ptr_model + 11'd1;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_DATA; dat_w = 32'h34; sel = 4'h1;
        stall_acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack) stall_acks++;
        end
        check("stall_no_ack", stall_acks, 32'd0);
        c0 = commit_cnt;
        rom_ready = 1'b1;
        @(negedge clk);
        check("stall_ack_at_commit", {31'b0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        check("burst_no_bubble", commit_cnt - c0, 32'd5);
        check("burst_rom_we_off", {31'b0, rom_we}, 32'd0);
        wait_drain();
        read_check("status_3", A_STATUS, 32'h0000_0001);

        // 4: pointer wrap
        ptr_write(11'h7FF);
        data_write(8'h11);
        data_write(8'h22);
        wait_drain();
        read_check("ptr_wrap", A_PTR, 32'h0000_0001);
        // PTR per byte lane: only lane 0 written
        wb_write(A_PTR, 32'h0000_07AB, 4'h1);
        ptr_model = 11'h0AB;
        read_check("ptr_lane0", A_PTR, 32'h0000_00AB);

        // 5: RUN gating
        rom_ready = 1'b0;
        data_write(8'h61);
        data_write(8'h62);
        data_write(8'h63);
        wb_write(A_CTRL, 32'h1, 4'h1);
        read_check("ctrl_run", A_CTRL, 32'h1);
        check("core_held_queued", {31'b0, core_rst_n}, 32'd0);
        @(negedge clk);
        rom_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("core_held_last_commit", {31'b0, core_rst_n}, 32'd0);
        @(negedge clk);
        check("core_released", {31'b0, core_rst_n}, 32'd1);
        check("drain_5", exp_q.size(), 32'd0);
        data_write(8'h64);
        @(negedge clk);
        check("core_reheld_on_push", {31'b0, core_rst_n}, 32'd0);
        wait_drain();
        repeat (2) @(negedge clk);
        check("core_rereleased", {31'b0, core_rst_n}, 32'd1);
        wb_write(A_CTRL, 32'h0, 4'h1);
        check("core_still_high", {31'b0, core_rst_n}, 32'd1);
        @(negedge clk);
        check("core_dropped", {31'b0, core_rst_n}, 32'd0);

        // 6: out-of-window access and reset during a stall
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h3000_0100; dat_w = 32'h1; sel = 4'hF;
        stall_acks = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack) stall_acks++;
        end
        check("out_of_window", stall_acks, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        read_check("ctrl_untouched", A_CTRL, 32'h0);

        rom_ready = 1'b0;
        for (int i = 0; i < 4; i++) data_write(8'h70 + 8'(i));
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_DATA; dat_w = 32'h77; sel = 4'h1;
        stall_acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (ack) stall_acks++;
        end
        rst_n = 1'b0;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (ack) stall_acks++;
        end
        rst_n = 1'b1;
        exp_q.delete();
        ptr_model = '0;
        repeat (2) begin
            @(negedge clk);
            if (ack) stall_acks++;
        end
        check("reset_no_ack", stall_acks, 32'd0);
        check("reset_rom_we", {31'b0, rom_we}, 32'd0);
        read_check("status_after_rst", A_STATUS, 32'h0000_0001);
        read_check("ptr_after_rst",    A_PTR,    32'h0000_0000);
        rom_ready = 1'b1;
        c0 = commit_cnt;
        repeat (4) @(negedge clk);
        #2;
        check("no_commit_after_rst", commit_cnt - c0, 32'd0);
        data_write(8'h99);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
